// File: rtl/load_store_unit.sv
// Load/store unit: decodes RISC-V loads/stores, drives a byte-enabled word-aligned
// memory request, waits for a multi-cycle acknowledge and returns extended load data.
module load_store_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int unsigned BE_W   = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(BE_W);
    localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam bit IS32  = (XLEN == 32);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [LANE_W-1:0]   lane_q;
    logic [2:0]          funct3_q;
    logic                we_q;

    logic                illegal_c, misaligned_c, accept_c, timeout_c;
    logic [LANE_W-1:0]   lane_c;
    logic [7:0]          mask_c;
    logic [BE_W-1:0]     be_c;
    logic [XLEN-1:0]     wdata_c;
    logic [XLEN-1:0]     shifted_c, load_c;

    // Request decode: legality, alignment, lane placement of store data
    always_comb begin
        illegal_c    = (req_funct3 == 3'b111) || (req_we && req_funct3[2]) ||
                       (IS32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
        misaligned_c = 1'b0;
        mask_c       = 8'h01;
        case (req_funct3[1:0])
            2'b01:   begin misaligned_c = req_addr[0];        mask_c = 8'h03; end
            2'b10:   begin misaligned_c = |req_addr[1:0];     mask_c = 8'h0F; end
            2'b11:   begin misaligned_c = |req_addr[2:0];     mask_c = 8'hFF; end
            default: begin misaligned_c = 1'b0;               mask_c = 8'h01; end
        endcase
        lane_c  = req_addr[LANE_W-1:0];
        be_c    = BE_W'(mask_c) << lane_c;
        wdata_c = req_wdata << {lane_c, 3'b000};
    end

    // Load lane extraction and sign/zero extension of captured read data
    always_comb begin
        shifted_c = mem_rdata >> {lane_q, 3'b000};
        load_c    = shifted_c;
        case (funct3_q[1:0])
            2'b00:   load_c = funct3_q[2] ? XLEN'(shifted_c[7:0])  : XLEN'($signed(shifted_c[7:0]));
            2'b01:   load_c = funct3_q[2] ? XLEN'(shifted_c[15:0]) : XLEN'($signed(shifted_c[15:0]));
            2'b10:   load_c = funct3_q[2] ? XLEN'(shifted_c[31:0]) : XLEN'($signed(shifted_c[31:0]));
            default: load_c = shifted_c;
        endcase
    end

    // Next-state logic; an ack on the final timeout cycle still completes normally
    always_comb begin
        state_n   = state;
        accept_c  = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    state_n  = (illegal_c || misaligned_c) ? RESP : BUS;
                end
            end
            BUS: begin
                if (mem_ack) begin
                    state_n = RESP;
                end else if (TO_EN && cnt == CNT_LAST) begin
                    timeout_c = 1'b1;
                    state_n   = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lane_q    <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == IDLE);
            mem_req   <= (state_n == BUS);
            rsp_valid <= (state_n == RESP);
            if (state == BUS && !mem_ack) cnt <= cnt + CNT_W'(1);
            if (accept_c) begin
                cnt      <= '0;
                lane_q   <= lane_c;
                funct3_q <= req_funct3;
                we_q     <= req_we;
                if (illegal_c) begin
                    rsp_err   <= 2'b10;
                    rsp_rdata <= '0;
                end else if (misaligned_c) begin
                    rsp_err   <= 2'b01;
                    rsp_rdata <= '0;
                end else begin
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
                    mem_be    <= be_c;
                    mem_wdata <= wdata_c;
                end
            end
            if (state == BUS && mem_ack) begin
                rsp_err   <= 2'b00;
                rsp_rdata <= we_q ? '0 : load_c;
            end else if (timeout_c) begin
                rsp_err   <= 2'b11;
                rsp_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, TIMEOUT=4) with a transaction-level
// reference model and a per-cycle output comparator.
module tb_load_store_unit;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    localparam bit [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_D = 3'd3;
    localparam bit [2:0] F_BU = 3'd4, F_HU = 3'd5, F_WU = 3'd6, F_BAD = 3'd7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_err;
    logic              mem_req, mem_we, mem_ack;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_be;

    load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        bus;
        bit [1:0]  err;
        bit [31:0] rdata;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [31:0] wdata;
    } exp_t;

    int        errors = 0;
    int        checks = 0;
    exp_t      cur;
    bit        cur_we;
    bit        active = 1'b0;
    logic      last_we;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic [1:0]  last_err;
    int        last_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what one access must produce, from size/lane/sign arithmetic
    function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                   input bit [31:0] wdata, input bit [31:0] rdata);
        exp_t e;
        int nbytes, lane;
        bit legal;
        longint unsigned mask, val;
        e = '{default: 0};
        nbytes = 1 << f3[1:0];
        lane   = int'(addr % 4);
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) begin e.err = 2'b10; return e; end
        if (addr % nbytes != 0) begin e.err = 2'b01; return e; end
        e.bus   = 1'b1;
        e.addr  = addr - 32'(lane);
        e.be    = 4'(((1 << nbytes) - 1) << lane);
        e.wdata = 32'(longint'(wdata) << (8 * lane));
        if (!we) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            val  = (longint'(rdata) >> (8 * lane)) & mask;
            if (!f3[2] && val[8 * nbytes - 1]) val = val | ~mask;
            e.rdata = 32'(val);
        end
        return e;
    endfunction

    // Per-cycle comparison of the live outputs against the current expectation
    always begin
        @(posedge clk);
        #1;
        if (active && rst_n) begin
            check("idle_iff_ready", 64'(req_ready), 64'(!(mem_req || rsp_valid)));
            if (mem_req) begin
                check("mem_we", 64'(mem_we), 64'(cur_we));
                check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                check("mem_be", 64'(mem_be), 64'(cur.be));
                check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                check("no_rsp_in_bus", 64'(rsp_valid), 64'(0));
            end
            if (rsp_valid) begin
                check("rsp_err", 64'(rsp_err), 64'(cur.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
            end
        end
    end

    // ack_wait: BUS cycles before ack (-1 = never); hold: cycles with rsp_ready low
    task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wdata, input bit [31:0] rdata,
                           input int ack_wait, input int hold, input bit late_ack);
        exp_t e;
        int exp_cycles, req_cycles;
        logic [31:0] held;
        e = model(we, f3, addr, wdata, rdata);
        if (!e.bus) exp_cycles = 0;
        else if (ack_wait >= 0 && ack_wait < int'(TIMEOUT)) exp_cycles = ack_wait + 1;
        else begin
            exp_cycles = int'(TIMEOUT);
            e.err   = 2'b11;
            e.rdata = '0;
        end
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'(1));
        cur = e; cur_we = we; active = 1'b1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        last_we = mem_we; last_be = mem_be; last_addr = mem_addr; last_wdata = mem_wdata;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_req) break;
            req_cycles++;
            mem_ack   = (ack_wait == i);
            mem_rdata = (ack_wait == i) ? rdata : $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check("mem_req_cycles", 64'(req_cycles), 64'(exp_cycles));
        check("rsp_valid_rise", 64'(rsp_valid), 64'(1));
        last_lat = req_cycles + 1;
        last_rdata = rsp_rdata; last_err = rsp_err; held = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            mem_ack = late_ack && (h == 0);
            @(negedge clk);
            mem_ack = 1'b0;
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_rdata", 64'(rsp_rdata), 64'(held));
            check("hold_not_ready", 64'(req_ready), 64'(0));
            check("hold_no_mem_req", 64'(mem_req), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_dropped", 64'(rsp_valid), 64'(0));
        check("back_to_idle", 64'(req_ready), 64'(1));
        active = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0; mem_ack = 0; mem_rdata = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_mem_be", 64'(mem_be), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(0, F_B, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        check("lb_addr", 64'(last_addr), 64'(32'h1000));
        check("lb_be", 64'(last_be), 64'(4'b1000));
        check("lb_rdata", 64'(last_rdata), 64'(32'hFFFF_FF80));
        check("lb_err", 64'(last_err), 64'(0));
        check("lb_latency", 64'(last_lat), 64'(2));

        // Ack on the fourth BUS cycle coincides with the timeout limit: ack wins
        run_txn(0, F_HU, 32'h2002, 32'h0, 32'hBEEF_0000, 3, 0, 0);
        check("lhu_rdata", 64'(last_rdata), 64'(32'h0000_BEEF));
        check("lhu_err", 64'(last_err), 64'(0));

        run_txn(1, F_H, 32'h3002, 32'h0000_ABCD, 32'hFFFF_FFFF, 1, 0, 0);
        check("sh_we", 64'(last_we), 64'(1));
        check("sh_be", 64'(last_be), 64'(4'b1100));
        check("sh_wdata_hi", 64'(last_wdata[31:16]), 64'(16'hABCD));
        check("sh_rdata", 64'(last_rdata), 64'(0));

        run_txn(0, F_W, 32'h4001, 32'h0, 32'h0, 0, 0, 0);
        check("lw_mis_err", 64'(last_err), 64'(2'b01));
        check("lw_mis_latency", 64'(last_lat), 64'(1));
        run_txn(0, F_D, 32'h4000, 32'h0, 32'h0, 0, 0, 0);
        check("ld32_err", 64'(last_err), 64'(2'b10));

        run_txn(0, F_W, 32'h5000, 32'h0, 32'h0, -1, 2, 1);
        check("timeout_err", 64'(last_err), 64'(2'b11));
        check("timeout_rdata", 64'(last_rdata), 64'(0));
        run_txn(0, F_W, 32'h5004, 32'h0, 32'h1234_5678, 0, 0, 0);
        check("after_to_rdata", 64'(last_rdata), 64'(32'h1234_5678));
        check("after_to_err", 64'(last_err), 64'(0));

        run_txn(0, F_B, 32'h6001, 32'h0, 32'h0000_7F00, 2, 5, 0);
        check("lb_pos_rdata", 64'(last_rdata), 64'(32'h0000_007F));

        run_txn(0, F_BU, 32'h7002, 32'h0, 32'h00AB_0000, 1, 0, 0);
        check("lbu_rdata", 64'(last_rdata), 64'(32'h0000_00AB));
        run_txn(0, F_H, 32'h7002, 32'h0, 32'h8001_0000, 0, 1, 0);
        check("lh_rdata", 64'(last_rdata), 64'(32'hFFFF_8001));
        run_txn(1, F_B, 32'h8001, 32'h0000_0055, 32'h0, 0, 0, 0);
        check("sb_be", 64'(last_be), 64'(4'b0010));
        check("sb_wdata", 64'(last_wdata[15:8]), 64'(8'h55));
        run_txn(1, F_W, 32'h8000, 32'hCAFE_F00D, 32'h0, 2, 0, 0);
        check("sw_be", 64'(last_be), 64'(4'b1111));
        run_txn(1, F_BU, 32'h8000, 32'h0, 32'h0, 0, 0, 0);
        check("store_f100_err", 64'(last_err), 64'(2'b10));
        run_txn(0, F_WU, 32'h8000, 32'h0, 32'h0, 0, 0, 0);
        check("lwu32_err", 64'(last_err), 64'(2'b10));
        run_txn(1, F_H, 32'h8003, 32'h1, 32'h0, 0, 0, 0);
        check("sh_mis_err", 64'(last_err), 64'(2'b01));
        run_txn(0, F_BAD, 32'h8003, 32'h0, 32'h0, 0, 0, 0);
        check("f111_err", 64'(last_err), 64'(2'b10));

        // Stray ack while idle must not start anything
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        check("idle_ack_no_req", 64'(mem_req), 64'(0));
        check("idle_ack_no_rsp", 64'(rsp_valid), 64'(0));
        check("idle_ack_ready", 64'(req_ready), 64'(1));

        // Asynchronous reset in the middle of a bus access
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h9000;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_mem_req", 64'(mem_req), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", 64'(mem_req), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(1));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_mem_be", 64'(mem_be), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, F_W, 32'h9008, 32'h0, 32'hA5A5_5A5A, 2, 0, 0);
        check("post_rst_rdata", 64'(last_rdata), 64'(32'hA5A5_5A5A));
        check("post_rst_err", 64'(last_err), 64'(0));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised load/store unit between the execute stage and the data-memory port of the RISC-V core.
- Accepts one load or store per handshake and decodes the access size from RISC-V funct3.
- Checks alignment, drives a byte-enabled, word-aligned memory request, and waits for a multi-cycle acknowledge.
- Returns lane-extracted, sign- or zero-extended load data with an error code; a timeout guards a stalled memory.

Parameters:
XLEN, 32, data width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
TIMEOUT, 16, max cycles in BUS without mem_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  address with low log2(XLEN/8) bits forced to 0
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  store data replicated/shifted into the addressed lane
mem_ack  in  1  memory completes the access (sampled only while mem_req=1)
mem_rdata  in  XLEN  read data, valid when mem_ack=1

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - State IDLE. mem_req=0, rsp_valid=0, req_ready=1.
  - mem_we, mem_addr, mem_be, mem_wdata, rsp_rdata and rsp_err all 0.
  - The timeout counter clears to 0.
- FSM states: IDLE, BUS, RESP. Only IDLE drives req_ready=1.
- IDLE, accept when req_valid & req_ready:
  - Register request fields.
  - Illegal funct3 -> RESP with rsp_err=10. Illegal means: 111; 110 or 011 when XLEN=32; any store funct3 >= 100.
  - Misaligned access -> RESP with rsp_err=01. Misaligned means: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0.
  - Otherwise -> BUS.
  - Error paths issue no memory transaction.
- BUS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata stay constant for the whole state.
  - mem_be marks 1, 2, 4 or 8 bytes starting at lane addr[log2(XLEN/8)-1:0].
  - mem_wdata = req_wdata shifted left by lane*8.
  - On a cycle with mem_ack=1: capture mem_rdata, go to RESP, rsp_err=00, mem_req drops on that edge.
  - Counter increments on each BUS cycle without ack. When it reaches TIMEOUT-1 with no ack: go to RESP with rsp_err=11 and drop mem_req.
- RESP:
  - rsp_valid=1. Go to IDLE on the cycle rsp_valid & rsp_ready.
  - rsp_valid and rsp_rdata stay stable while rsp_ready=0.
- Load extraction:
  - Shift captured data right by lane*8, then truncate to the access size.
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend; LD passes through.
- Latency:
  - Error response: rsp_valid rises on the edge after accept.
  - Good access: mem_req rises on the edge after accept; rsp_valid rises on the edge that samples mem_ack.
  - Minimum accept-to-rsp_valid latency is 2 cycles.
- Boundary cases:
  - mem_ack outside BUS is ignored, including a late ack after a timeout.
  - Ack on the same cycle the counter hits TIMEOUT-1 completes with rsp_err=00 (ack wins).
  - No new request is accepted while in RESP; there is no pipelining.
  - rsp_rdata=0 for stores and for all errors.

Test Plan:
- XLEN=32, LB addr=0x1003, mem_rdata=0x80FF_1234, ack in 1st BUS cycle -> mem_addr=0x1000, mem_be=1000, rsp_rdata=0xFFFF_FF80, rsp_err=00, rsp_valid 2 cycles after accept.
- LHU addr=0x2002, mem_rdata=0xBEEF_0000, ack after 3 wait cycles -> mem_req high 4 cycles, rsp_rdata=0x0000_BEEF.
- SH addr=0x3002, wdata=0x0000_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_xxxx (upper half 0xABCD), rsp_rdata=0.
- LW addr=0x4001 -> no mem_req ever, rsp_err=01 one cycle after accept. funct3=011 at XLEN=32 -> rsp_err=10.
- TIMEOUT=4, never ack -> mem_req high exactly 4 cycles, then rsp_err=11. Ack injected after the abort is ignored; the next request completes normally.
- rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0. Separately, rst_n pulsed low mid-BUS -> mem_req drops immediately, state IDLE, req_ready=1.
